// File: rtl/io_port_check_pkg.sv
// Shared constants and helpers for the I/O port readiness checker.
// Provides the EF polarity names (FULL/EMPTY), boolean names (TRUE/FALSE),
// holdoff counter sizing and the port-index width helper.
package io_port_check_pkg;

    // Empty/Full flag polarity as seen on port_EF.
    localparam logic FULL  = 1'b1;
    localparam logic EMPTY = 1'b0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Holdoff is limited to 0..7 cycles, so a 3-bit counter is enough.
    localparam int HOLDOFF_MAX   = 7;
    localparam int HOLDOFF_WIDTH = 3;

    // Width of a port index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_port_check_if.sv
// Operand/port bundle between the pipeline front end and io_port_check.
// master drives addresses, EF bits and enable; slave returns hits, masked EF,
// all_ready, per-port access pulses and the stall count.
interface io_port_check_if #(
    parameter int ADDR_WIDTH    = 10,
    parameter int PORT_COUNT    = 4,
    parameter int CHANNEL_COUNT = 2,
    parameter int STALL_WIDTH   = 8
);
    logic [CHANNEL_COUNT*ADDR_WIDTH-1:0] addr;
    logic [CHANNEL_COUNT-1:0]            addr_valid;
    logic [PORT_COUNT-1:0]               port_EF;
    logic                                enable;
    logic [CHANNEL_COUNT-1:0]            addr_is_IO;
    logic [CHANNEL_COUNT-1:0]            port_EF_masked;
    logic                                all_ready;
    logic [PORT_COUNT-1:0]               port_access;
    logic [STALL_WIDTH-1:0]              stall_count;

    modport master (
        output addr, addr_valid, port_EF, enable,
        input  addr_is_IO, port_EF_masked, all_ready, port_access, stall_count
    );

    modport slave (
        input  addr, addr_valid, port_EF, enable,
        output addr_is_IO, port_EF_masked, all_ready, port_access, stall_count
    );
endinterface

// File: rtl/io_port_decode.sv
// Per-channel decoder: range compare against the port window, port index
// extraction and EF select. Purely combinational (registered by the parent).
// Ports: addr/addr_valid/port_EF in; hit, idx, ef_sel (READY_STATE when no hit) out.
module io_port_decode
    import io_port_check_pkg::*;
#(
    parameter int   ADDR_WIDTH     = 10,
    parameter int   PORT_COUNT     = 4,
    parameter int   PORT_BASE_ADDR = 0,
    parameter logic READY_STATE    = FULL,
    parameter int   IDX_WIDTH      = idx_width(PORT_COUNT)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  addr_valid,
    input  logic [PORT_COUNT-1:0] port_EF,
    output logic                  hit,
    output logic [IDX_WIDTH-1:0]  idx,
    output logic                  ef_sel
);
    // Compare in 32 bits so base+count cannot wrap inside the address width.
    localparam logic [31:0] LO = 32'(PORT_BASE_ADDR);
    localparam logic [31:0] HI = 32'(PORT_BASE_ADDR + PORT_COUNT);

    logic [31:0] addr_ext;

    assign addr_ext = 32'(addr);
    assign hit      = addr_valid && (addr_ext >= LO) && (addr_ext < HI);
    assign idx      = IDX_WIDTH'(addr_ext - LO);
    // A non-I/O channel must never hold up the pipeline, so it reads as ready.
    assign ef_sel   = hit ? port_EF[idx] : READY_STATE;
endmodule

// File: rtl/io_port_check.sv
// Two-stage I/O port readiness check: stage 1 registers hit/EF per channel,
// stage 2 registers all_ready; access pulses and holdoff/stall tracking follow.
// Latency: hit/masked EF at N+1, all_ready/port_access at N+2. No backpressure
// input; not-ready is reported via all_ready and stall_count.
// Ports: clock, reset_n (async, active-low), bus (slave side of io_port_check_if).
module io_port_check
    import io_port_check_pkg::*;
#(
    parameter int   ADDR_WIDTH     = 10,
    parameter int   PORT_COUNT     = 4,
    parameter int   PORT_BASE_ADDR = 0,
    parameter int   CHANNEL_COUNT  = 2,
    parameter logic READY_STATE    = FULL,
    parameter int   HOLDOFF        = 2,
    parameter int   STALL_WIDTH    = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    io_port_check_if.slave bus
);
    localparam int   IDX_WIDTH = idx_width(PORT_COUNT);
    localparam logic HOLD_EN   = (HOLDOFF > 0) ? TRUE : FALSE;
    // The pulse cycle itself is the first lockout cycle, so the stored count
    // only needs to cover the remaining HOLDOFF-1 cycles.
    localparam logic [HOLDOFF_WIDTH-1:0] HOLD_RELOAD =
        HOLDOFF_WIDTH'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [CHANNEL_COUNT-1:0] dec_hit;
    logic [CHANNEL_COUNT-1:0] dec_ef;
    logic [IDX_WIDTH-1:0]     dec_idx [CHANNEL_COUNT];

    logic [CHANNEL_COUNT-1:0] s1_hit;
    logic [CHANNEL_COUNT-1:0] s1_ef;
    logic [IDX_WIDTH-1:0]     s1_idx [CHANNEL_COUNT];

    logic                     s2_all_ready;
    logic [CHANNEL_COUNT-1:0] s2_hit;
    logic [IDX_WIDTH-1:0]     s2_idx [CHANNEL_COUNT];

    logic [CHANNEL_COUNT-1:0] ch_ready;
    logic [PORT_COUNT-1:0]    port_hit2;
    logic [PORT_COUNT-1:0]    access;
    logic [PORT_COUNT-1:0]    port_busy;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt [PORT_COUNT];
    logic [STALL_WIDTH-1:0]   stall_q;

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
        io_port_decode #(
            .ADDR_WIDTH     (ADDR_WIDTH),
            .PORT_COUNT     (PORT_COUNT),
            .PORT_BASE_ADDR (PORT_BASE_ADDR),
            .READY_STATE    (READY_STATE),
            .IDX_WIDTH      (IDX_WIDTH)
        ) u_dec (
            .addr       (bus.addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
            .addr_valid (bus.addr_valid[c]),
            .port_EF    (bus.port_EF),
            .hit        (dec_hit[c]),
            .idx        (dec_idx[c]),
            .ef_sel     (dec_ef[c])
        );
    end

    // Stage 1: decoded hit, index and EF sampled with the address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit <= '0;
            s1_ef  <= {CHANNEL_COUNT{READY_STATE}};
            for (int c = 0; c < CHANNEL_COUNT; c++) s1_idx[c] <= '0;
        end else begin
            s1_hit <= dec_hit;
            s1_ef  <= dec_ef;
            s1_idx <= dec_idx;
        end
    end

    // A port accessed this cycle is already locked, so a back-to-back
    // operand on the same port cannot slip through before the count loads.
    always_comb begin
        for (int p = 0; p < PORT_COUNT; p++) begin
            port_busy[p] = (HOLD_EN && access[p]) || (hold_cnt[p] != '0);
        end
    end

    always_comb begin
        ch_ready = '1;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            if (s1_ef[c] != READY_STATE) begin
                ch_ready[c] = 1'b0;
            end else if (s1_hit[c] && port_busy[s1_idx[c]]) begin
                ch_ready[c] = 1'b0;
            end
        end
    end

    // Stage 2: combined readiness plus the hits that will drive access pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_all_ready <= 1'b1;
            s2_hit       <= '0;
            for (int c = 0; c < CHANNEL_COUNT; c++) s2_idx[c] <= '0;
        end else begin
            s2_all_ready <= &ch_ready;
            s2_hit       <= s1_hit;
            s2_idx       <= s1_idx;
        end
    end

    // OR of channel hits per port: two channels on one port give one pulse.
    always_comb begin
        port_hit2 = '0;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            if (s2_hit[c]) port_hit2[s2_idx[c]] = 1'b1;
        end
        access = (s2_all_ready && bus.enable) ? port_hit2 : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < PORT_COUNT; p++) hold_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (HOLD_EN && access[p]) begin
                    hold_cnt[p] <= HOLD_RELOAD;
                end else if (hold_cnt[p] != '0) begin
                    hold_cnt[p] <= hold_cnt[p] - 1'b1;
                end
            end
        end
    end

    // Clear wins regardless of enable; counting only for live instructions.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (s2_all_ready) begin
            stall_q <= '0;
        end else if (bus.enable && (|s2_hit) && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.addr_is_IO     = s1_hit;
    assign bus.port_EF_masked = s1_ef;
    assign bus.all_ready      = s2_all_ready;
    assign bus.port_access    = access;
    assign bus.stall_count    = stall_q;
endmodule

// File: tb/tb_io_port_check.sv
// Self-checking bench for io_port_check: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model that
// tracks lockout as "cycles since last access" and stall as a saturating int.
module tb_io_port_check;
    localparam int AW   = 10;
    localparam int PC   = 4;
    localparam int BASE = 8;
    localparam int CC   = 2;
    localparam int HOLD = 2;
    localparam int SW   = 4;
    localparam int SAT  = (1 << SW) - 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    io_port_check_if #(
        .ADDR_WIDTH(AW), .PORT_COUNT(PC), .CHANNEL_COUNT(CC), .STALL_WIDTH(SW)
    ) bus ();

    io_port_check #(
        .ADDR_WIDTH     (AW),
        .PORT_COUNT     (PC),
        .PORT_BASE_ADDR (BASE),
        .CHANNEL_COUNT  (CC),
        .READY_STATE    (1'b1),
        .HOLDOFF        (HOLD),
        .STALL_WIDTH    (SW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference model: inputs seen one and two cycles ago, cycle of last
    // access per port, expected all_ready for the coming cycle, stall count.
    logic [AW-1:0] h1_addr [CC];
    logic [AW-1:0] h2_addr [CC];
    logic [CC-1:0] h1_vld, h2_vld;
    logic [PC-1:0] h1_ef;
    int            last_acc [PC];
    logic          m_ready;
    int            m_stall;

    logic [CC-1:0] obs_io, obs_mask;
    logic          obs_ar;
    logic [PC-1:0] obs_acc;
    logic [SW-1:0] obs_stall;

    function automatic bit is_port(input logic [AW-1:0] a, input logic v);
        return v && (int'(a) >= BASE) && (int'(a) < BASE + PC);
    endfunction

    task automatic clear_model();
        for (int c = 0; c < CC; c++) begin
            h1_addr[c] = '0;
            h2_addr[c] = '0;
        end
        h1_vld  = '0;
        h2_vld  = '0;
        h1_ef   = '0;
        for (int p = 0; p < PC; p++) last_acc[p] = -100;
        m_ready = 1'b1;
        m_stall = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, predict, compare at
    // the falling edge, then advance the model.
    task automatic cycle(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [CC-1:0] v, input logic [PC-1:0] ef,
                         input logic en, input logic rst);
        logic [CC-1:0] e_io, e_mask;
        logic          e_ar, n_ready;
        logic [PC-1:0] ports2, e_acc;
        int            e_stall, n_stall, ix;
        logic [AW-1:0] cur [CC];

        @(posedge clock);
        #1;
        bus.addr       = {a1, a0};
        bus.addr_valid = v;
        bus.port_EF    = ef;
        bus.enable     = en;
        reset_n        = rst;
        cur[0] = a0;
        cur[1] = a1;

        if (!rst) clear_model();

        e_io   = '0;
        e_mask = '1;
        for (int c = 0; c < CC; c++) begin
            if (is_port(h1_addr[c], h1_vld[c])) begin
                e_io[c]   = 1'b1;
                e_mask[c] = h1_ef[int'(h1_addr[c]) - BASE];
            end
        end
        e_ar   = m_ready;
        ports2 = '0;
        for (int c = 0; c < CC; c++) begin
            if (is_port(h2_addr[c], h2_vld[c])) ports2[int'(h2_addr[c]) - BASE] = 1'b1;
        end
        e_acc = (e_ar && en) ? ports2 : '0;
        for (int p = 0; p < PC; p++) if (e_acc[p]) last_acc[p] = cyc;
        e_stall = m_stall;
        if (e_ar)                      n_stall = 0;
        else if (en && ports2 != '0)   n_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        else                           n_stall = m_stall;
        n_ready = 1'b1;
        for (int c = 0; c < CC; c++) begin
            if (e_io[c]) begin
                ix = int'(h1_addr[c]) - BASE;
                if (h1_ef[ix] !== 1'b1 || (cyc - last_acc[ix]) < HOLD) n_ready = 1'b0;
            end
        end

        @(negedge clock);
        obs_io    = bus.addr_is_IO;
        obs_mask  = bus.port_EF_masked;
        obs_ar    = bus.all_ready;
        obs_acc   = bus.port_access;
        obs_stall = bus.stall_count;
        chk("addr_is_IO",     32'(obs_io),    32'(e_io));
        chk("port_EF_masked", 32'(obs_mask),  32'(e_mask));
        chk("all_ready",      32'(obs_ar),    32'(e_ar));
        chk("port_access",    32'(obs_acc),   32'(e_acc));
        chk("stall_count",    32'(obs_stall), 32'(e_stall));

        if (!rst) begin
            clear_model();
        end else begin
            h2_addr = h1_addr;
            h2_vld  = h1_vld;
            h1_addr = cur;
            h1_vld  = v;
            h1_ef   = ef;
            m_ready = n_ready;
            m_stall = n_stall;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, 4'b1111, 1'b1, 1'b1);
    endtask

    initial begin
        logic [PC-1:0] hk_acc [6];
        logic          hk_ar  [6];
        logic [AW-1:0] ra [CC];
        logic [PC-1:0] ref_ef;

        bus.addr       = '0;
        bus.addr_valid = '0;
        bus.port_EF    = '0;
        bus.enable     = 1'b0;
        clear_model();

        // Reset state.
        repeat (3) cycle('0, '0, '0, '0, 1'b1, 1'b0);
        chk("rst_all_ready", 32'(obs_ar), 32'h1);
        chk("rst_masked",    32'(obs_mask), 32'h3);
        chk("rst_access",    32'(obs_acc), 32'h0);
        idle(3);

        // Read-mode ready: address 9 -> port 1, EF of port 1 full.
        cycle(10'd9, '0, 2'b01, 4'b0010, 1'b1, 1'b1);
        cycle('0, '0, '0, 4'b0010, 1'b1, 1'b1);
        chk("rd_io",   32'(obs_io[0]), 32'h1);
        chk("rd_mask", 32'(obs_mask[0]), 32'h1);
        cycle('0, '0, '0, 4'b0010, 1'b1, 1'b1);
        chk("rd_ready",  32'(obs_ar), 32'h1);
        chk("rd_access", 32'(obs_acc), 32'h2);
        idle(3);

        // Memory-only operands, just below and far above the port window.
        cycle(10'd3, 10'd20, 2'b11, 4'b0000, 1'b1, 1'b1);
        idle(1);
        chk("mem_io", 32'(obs_io), 32'h0);
        idle(1);
        chk("mem_ready",  32'(obs_ar), 32'h1);
        chk("mem_access", 32'(obs_acc), 32'h0);
        idle(2);

        // Holdoff: back-to-back reads of port 1.
        for (int k = 0; k < 6; k++) begin
            cycle(10'd9, '0, 2'b01, 4'b0010, 1'b1, 1'b1);
            hk_acc[k] = obs_acc;
            hk_ar[k]  = obs_ar;
        end
        chk("hold_acc_n2",   32'(hk_acc[2]), 32'h2);
        chk("hold_ready_n3", 32'(hk_ar[3]),  32'h0);
        chk("hold_ready_n4", 32'(hk_ar[4]),  32'h0);
        chk("hold_acc_n4",   32'(hk_acc[4]), 32'h0);
        chk("hold_acc_n5",   32'(hk_acc[5]), 32'h2);
        idle(4);

        // Stall saturation with EF held empty, then release.
        repeat (20) cycle(10'd9, '0, 2'b01, 4'b0000, 1'b1, 1'b1);
        chk("stall_sat", 32'(obs_stall), 32'(SAT));
        cycle(10'd9, '0, 2'b01, 4'b0010, 1'b1, 1'b1);
        idle(4);
        chk("stall_clear", 32'(obs_stall), 32'h0);
        idle(3);

        // Both channels on port 2 give one pulse.
        cycle(10'd10, 10'd10, 2'b11, 4'b0100, 1'b1, 1'b1);
        idle(2);
        chk("dual_access", 32'(obs_acc), 32'h4);
        idle(3);

        // Reset asserted in the cycle the access pulse is due.
        cycle(10'd9, '0, 2'b01, 4'b0010, 1'b1, 1'b1);
        cycle('0, '0, '0, 4'b0010, 1'b1, 1'b1);
        cycle('0, '0, '0, 4'b0010, 1'b1, 1'b0);
        chk("midrst_access", 32'(obs_acc), 32'h0);
        chk("midrst_ready",  32'(obs_ar),  32'h1);
        chk("midrst_io",     32'(obs_io),  32'h0);
        cycle('0, '0, '0, 4'b0010, 1'b1, 1'b0);
        idle(3);

        // Randomized traffic clustered around the port window boundaries.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CC; c++) begin
                ra[c] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 1023))
                                                    : AW'($urandom_range(5, 14));
            end
            for (int p = 0; p < PC; p++) ref_ef[p] = ($urandom_range(0, 3) != 0);
            cycle(ra[0], ra[1], CC'($urandom_range(0, 3)), ref_ef,
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 99) != 0));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_port_check.md
IO_PORT_CHECK -- requirements
Module: io_port_check

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: width of each operand address.
REQ-002 SHALL have parameter PORT_COUNT, default 4: number of I/O ports.
REQ-003 SHALL have parameter PORT_BASE_ADDR, default 0: address of port 0; ports occupy PORT_BASE_ADDR..PORT_BASE_ADDR+PORT_COUNT-1.
REQ-004 SHALL have parameter CHANNEL_COUNT, default 2: operand addresses checked in parallel.
REQ-005 SHALL have parameter READY_STATE, default FULL: EF value meaning "ready" (FULL for reads, EMPTY for writes).
REQ-006 SHALL have parameter HOLDOFF, default 2: cycles a port stays not-ready after an access, range 0..7.
REQ-007 SHALL have parameter STALL_WIDTH, default 8: width of the stall counter.
REQ-008 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-009 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port addr, input, CHANNEL_COUNT*ADDR_WIDTH: packed addresses, channel 0 in LSBs.
REQ-011 SHALL have port addr_valid, input, CHANNEL_COUNT: channel carries a real operand.
REQ-012 SHALL have port port_EF, input, PORT_COUNT: per-port Empty/Full bits.
REQ-013 SHALL have port enable, input, 1: stage-2 instruction not annulled.
REQ-014 SHALL have port addr_is_IO, output, CHANNEL_COUNT: stage-1 I/O hit per channel.
REQ-015 SHALL have port port_EF_masked, output, CHANNEL_COUNT: stage-1 masked EF per channel.
REQ-016 SHALL have port all_ready, output, 1: stage-2, every channel ready.
REQ-017 SHALL have port port_access, output, PORT_COUNT: stage-2 one-cycle access pulses.
REQ-018 SHALL have port stall_count, output, STALL_WIDTH: consecutive not-ready cycles, saturating.

Function
REQ-019 SHALL register, for addr presented at cycle N, per-channel hit, port index and port_EF[index] sampled at N, visible on addr_is_IO/port_EF_masked at N+1.
REQ-020 SHALL set hit only when addr_valid is 1 and addr lies inside the port range; out-of-range or invalid channels are non-I/O.
REQ-021 SHALL drive port_EF_masked = selected EF when hit, else READY_STATE.
REQ-022 SHALL deem a channel ready when port_EF_masked equals READY_STATE and its port is not in holdoff.
REQ-023 SHALL register the AND of channel readiness onto all_ready at N+2, together with registered hits and indices.
REQ-024 SHALL pulse port_access[p] at N+2 when all_ready, enable, and any stage-2 channel hits port p; multiple channels on one port give a single pulse.
REQ-025 SHALL load holdoff counter p with HOLDOFF on its access pulse; port p is not-ready while counter nonzero; counter decrements by 1 per cycle to 0.
REQ-026 SHALL, with HOLDOFF=0, apply no lockout.
REQ-027 SHALL increment stall_count each cycle all_ready is 0 with any stage-2 hit, saturate at all-ones, and clear to 0 on all_ready=1.
REQ-028 SHALL not touch stall_count or port_access when enable is 0, except the clear on all_ready=1.

Reset
REQ-029 SHALL, while reset_n is 0, force addr_is_IO=0, port_EF_masked=READY_STATE, all_ready=1, port_access=0, stall_count=0, holdoff counters=0.
REQ-030 SHALL discard any in-flight stage-1/2 state on reset mid-operation; first valid output is 2 cycles after release.

Structure
REQ-031 SHALL take FULL, EMPTY, TRUE, FALSE from the shared constants header; no local redefinition.
REQ-032 SHALL instantiate one sub-module io_port_decode per channel: range compare, index extraction, EF select.
REQ-033 SHALL keep holdoff counters and stall counter in the top level.

Verification
REQ-034 SHALL cover read-mode ready: PORT_BASE_ADDR=8, addr ch0=9, port_EF=4'b0010 -> addr_is_IO[0]=1, port_EF_masked[0]=1 at N+1; all_ready=1, port_access=4'b0010 at N+2.
REQ-035 SHALL cover memory-only: addr ch0=3, ch1=20 -> addr_is_IO=0, all_ready=1, port_access=0.
REQ-036 SHALL cover holdoff: HOLDOFF=2, back-to-back reads of port 1 with EF held 1 -> access at N+2, all_ready=0 at N+3 and N+4, access again at N+5.
REQ-037 SHALL cover stall saturation: STALL_WIDTH=4, port EF held 0 for 20 cycles -> stall_count reaches 15 and holds; EF=1 -> clears to 0.
REQ-038 SHALL cover both channels on port 2 -> single port_access[2] pulse.
REQ-039 SHALL cover reset_n low mid-access -> outputs at reset values in same cycle, no port_access pulse.
